// File: rtl/score_text_renderer.sv
// score_text_renderer
//   Converts the binary game score to four BCD digits once per frame and
//   renders them as an 8x16-font text box. It requests glyph rows from an
//   external ROM and extracts the pixel under the beam.
//
// Ports:
//   clk, rst            pixel clock, asynchronous active-high reset
//   pixel_x, pixel_y    current beam position
//   video_on            beam inside the visible area
//   frame_tick          one-cycle frame-start pulse; starts a score capture
//   score               binary score (saturated to 9999)
//   font_addr           glyph-ROM address {digit+1, row}, or 0 outside the box
//   font_data           glyph-ROM row byte, one cycle after font_addr
//   pixel_on            score pixel lit, 3 cycles after pixel_x/pixel_y
//   conv_busy           BCD conversion in progress
module score_text_renderer #(
    parameter logic [15:0] X0   = 16'd100,
    parameter logic [15:0] Y0   = 16'd50,
    parameter int          NDIG = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic [13:0] score,
    output logic [7:0]  font_addr,
    input  logic [7:0]  font_data,
    output logic        pixel_on,
    output logic        conv_busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t      state, state_nxt;
    logic [13:0] bin_q, bin_nxt;
    logic [15:0] bcd_q, bcd_nxt, bcd_adj;
    logic [3:0]  cnt_q, cnt_nxt;
    logic [15:0] disp_digits, disp_nxt;

    function automatic logic [13:0] sat_score(input logic [13:0] s);
        return (s > 14'd9999) ? 14'd9999 : s;
    endfunction

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
    function automatic logic [15:0] add3(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign bcd_adj = add3(bcd_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            disp_digits <= '0;
        end else begin
            state       <= state_nxt;
            bin_q       <= bin_nxt;
            bcd_q       <= bcd_nxt;
            cnt_q       <= cnt_nxt;
            disp_digits <= disp_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bin_nxt   = bin_q;
        bcd_nxt   = bcd_q;
        cnt_nxt   = cnt_q;
        disp_nxt  = disp_digits;
        conv_busy = 1'b0;
        case (state)
            IDLE: begin
                if (frame_tick) begin
                    bin_nxt   = sat_score(score);
                    bcd_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                conv_busy = 1'b1;
                bcd_nxt   = {bcd_adj[14:0], bin_q[13]};
                bin_nxt   = {bin_q[12:0], 1'b0};
                cnt_nxt   = cnt_q + 4'd1;
                if (cnt_q == 4'd13)
                    state_nxt = COMMIT;
            end
            COMMIT: begin
                conv_busy = 1'b1;
                disp_nxt  = bcd_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Box decode. Comparisons are done one bit wider than the parameters so
    // X0+32 / Y0+16 cannot wrap.
    logic [16:0] px_ext, py_ext, x_lo, x_hi, y_lo, y_hi;
    logic        in_box;
    logic [4:0]  dx;
    logic [3:0]  dy;
    logic [3:0]  digit;

    assign px_ext = {7'b0, pixel_x};
    assign py_ext = {7'b0, pixel_y};
    assign x_lo   = {1'b0, X0};
    assign x_hi   = x_lo + 17'(8 * NDIG);
    assign y_lo   = {1'b0, Y0};
    assign y_hi   = y_lo + 17'd16;
    assign in_box = video_on && (px_ext >= x_lo) && (px_ext < x_hi)
                             && (py_ext >= y_lo) && (py_ext < y_hi);
    // Only the low bits of the offsets matter once inside the box.
    assign dx     = pixel_x[4:0] - X0[4:0];
    assign dy     = pixel_y[3:0] - Y0[3:0];

    always_comb begin
        digit = disp_digits[15:12];
        case (dx[4:3])
            2'd0: digit = disp_digits[15:12];
            2'd1: digit = disp_digits[11:8];
            2'd2: digit = disp_digits[7:4];
            2'd3: digit = disp_digits[3:0];
            default: digit = disp_digits[15:12];
        endcase
    end

    logic       vld_p1, vld_p2;
    logic [2:0] col_p1, col_p2;

    // Stage 1: glyph address, column and inside flag
    // Stage 2: ROM returns font_data; column and flag follow
    // Stage 3: pixel extraction (bit 7 is the leftmost column, so ~col = 7-col)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            font_addr <= 8'h00;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            pixel_on  <= 1'b0;
        end else begin
            font_addr <= in_box ? {digit + 4'd1, dy} : 8'h00;
            vld_p1    <= in_box;
            vld_p2    <= vld_p1;
            pixel_on  <= vld_p2 & font_data[~col_p2];
        end
    end

    always_ff @(posedge clk) begin
        col_p1 <= dx[2:0];
        col_p2 <= col_p1;
    end

endmodule

// File: tb/tb_score_text_renderer.sv
module tb_score_text_renderer;

    localparam logic [15:0] X0 = 16'd100;
    localparam logic [15:0] Y0 = 16'd50;

    logic        clk;
    logic        rst;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        frame_tick;
    logic [13:0] score;
    logic [7:0]  font_addr;
    logic [7:0]  font_data;
    logic        pixel_on;
    logic        conv_busy;

    score_text_renderer #(.X0(X0), .Y0(Y0), .NDIG(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .frame_tick (frame_tick),
        .score      (score),
        .font_addr  (font_addr),
        .font_data  (font_data),
        .pixel_on   (pixel_on),
        .conv_busy  (conv_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Glyph ROM: registered read, address 0 returns 0.
    logic [7:0] rom [0:255];
    always @(posedge clk) font_data <= rom[font_addr];

    int n_tests = 0;
    int n_fail  = 0;
    int shown   = 0;   // value the model believes is on screen

    typedef struct {
        int x;
        int y;
        bit v;
    } pix_t;
    pix_t pq[$];

    task automatic check(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    function automatic int dec_digit(input int val, input int idx);
        int p;
        case (idx)
            0: p = 1000;
            1: p = 100;
            2: p = 10;
            default: p = 1;
        endcase
        return (val / p) % 10;
    endfunction

    function automatic int to_bcd(input int val);
        return (dec_digit(val, 0) << 12) | (dec_digit(val, 1) << 8) |
               (dec_digit(val, 2) << 4) | dec_digit(val, 3);
    endfunction

    function automatic bit in_box(input pix_t p);
        return p.v && p.x >= int'(X0) && p.x < int'(X0) + 32 &&
               p.y >= int'(Y0) && p.y < int'(Y0) + 16;
    endfunction

    function automatic int exp_addr(input pix_t p);
        int idx, row;
        if (!in_box(p)) return 0;
        idx = (p.x - int'(X0)) / 8;
        row = p.y - int'(Y0);
        return (dec_digit(shown, idx) + 1) * 16 + row;
    endfunction

    function automatic int exp_pix(input pix_t p);
        int col;
        logic [7:0] b;
        if (!in_box(p)) return 0;
        col = (p.x - int'(X0)) % 8;
        b = rom[exp_addr(p)];
        return int'(b[7 - col]);
    endfunction

    function automatic pix_t mk(input int x, input int y, input bit v);
        pix_t p;
        p.x = x;
        p.y = y;
        p.v = v;
        return p;
    endfunction

    task automatic add_random(input int n);
        for (int i = 0; i < n; i++)
            pq.push_back(mk(int'(X0) - 4 + int'($urandom_range(0, 40)),
                            int'(Y0) - 2 + int'($urandom_range(0, 20)),
                            $urandom_range(0, 7) != 0));
    endtask

    // Streams the queued pixels one per cycle; address checked one cycle
    // later, pixel_on three cycles later.
    task automatic run_pixels();
        int n;
        n = pq.size();
        for (int i = 0; i < n + 3; i++) begin
            @(negedge clk);
            if (i >= 1 && i <= n) check("font_addr", int'(font_addr), exp_addr(pq[i-1]));
            if (i >= 3) check("pixel_on", int'(pixel_on), exp_pix(pq[i-3]));
            if (i < n) begin
                pixel_x  = 10'(pq[i].x);
                pixel_y  = 10'(pq[i].y);
                video_on = pq[i].v;
            end else begin
                pixel_x  = '0;
                pixel_y  = '0;
                video_on = 1'b0;
            end
        end
        pq.delete();
    endtask

    task automatic convert(input int s, input bit collide);
        int hi;
        hi = 0;
        @(negedge clk);
        score      = 14'(s);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!conv_busy) break;
            hi++;
            if (collide && k == 4) begin
                score      = 14'd42;
                frame_tick = 1'b1;
            end else begin
                frame_tick = 1'b0;
                if (k == 2) score = 14'($urandom_range(0, 16383));
            end
            @(negedge clk);
        end
        frame_tick = 1'b0;
        check("busy_cycles", hi, 15);
        shown = (s > 9999) ? 9999 : s;
        check("disp_digits", int'(dut.disp_digits), to_bcd(shown));
    endtask

    initial begin
        rst        = 1'b0;
        pixel_x    = '0;
        pixel_y    = '0;
        video_on   = 1'b0;
        frame_tick = 1'b0;
        score      = '0;
        for (int a = 0; a < 256; a++) rom[a] = (a < 16) ? 8'h00 : 8'($urandom);
        rom[8'h10] = 8'h3C;   // '0' row 0
        rom[8'h20] = 8'h18;   // '1' row 0
        rom[8'hA9] = 8'h3C;   // '9' row 9
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_font_addr", int'(font_addr), 0);
        check("rst_pixel_on", int'(pixel_on), 0);
        check("rst_conv_busy", int'(conv_busy), 0);
        check("rst_disp", int'(dut.disp_digits), 0);
        rst = 1'b0;

        // "0000" displayed after reset
        pq.push_back(mk(int'(X0) + 3, int'(Y0), 1'b1));
        add_random(40);
        run_pixels();

        convert(1234, 1'b0);
        pq.push_back(mk(int'(X0) + 8, int'(Y0), 1'b1));
        add_random(50);
        run_pixels();

        convert(12000, 1'b0);
        pq.push_back(mk(int'(X0) + 24, int'(Y0) + 9, 1'b1));
        add_random(50);
        run_pixels();

        convert(1, 1'b0);
        for (int x = 0; x < 8; x++) pq.push_back(mk(int'(X0) + 24 + x, int'(Y0), 1'b1));
        pq.push_back(mk(int'(X0) - 1, int'(Y0), 1'b1));
        pq.push_back(mk(int'(X0) + 32, int'(Y0), 1'b1));
        pq.push_back(mk(int'(X0) + 5, int'(Y0) + 16, 1'b1));
        pq.push_back(mk(int'(X0) + 27, int'(Y0), 1'b0));
        pq.push_back(mk(int'(X0), int'(Y0) + 15, 1'b1));
        add_random(30);
        run_pixels();

        // second tick during SHIFT with a new score must be ignored
        convert(7777, 1'b1);
        add_random(30);
        run_pixels();

        // reset during SHIFT aborts the conversion
        @(negedge clk);
        score      = 14'd5555;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(conv_busy), 0);
        check("midrst_pixel_on", int'(pixel_on), 0);
        check("midrst_disp", int'(dut.disp_digits), 0);
        @(negedge clk);
        rst   = 1'b0;
        shown = 0;
        pq.push_back(mk(int'(X0) + 3, int'(Y0), 1'b1));
        add_random(30);
        run_pixels();
        repeat (20) @(negedge clk);
        check("midrst_no_commit", int'(dut.disp_digits), 0);

        for (int r = 0; r < 4; r++) begin
            convert(int'($urandom_range(0, 16383)), 1'b0);
            add_random(40);
            run_pixels();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
